// File: rtl/mips_mc.sv
// mips_mc: multi-cycle MIPS core on one unified, stallable memory bus.
// Optional jal/jr support is enabled by defining MIPS_MC_JAL_EN.
module mips_mc #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] pc,
  output logic        retire,
  output logic        trap
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    OP_ADDU, OP_SUBU, OP_AND, OP_OR, OP_SLT, OP_SLL,
    OP_ADDIU, OP_ORI, OP_LUI, OP_LW, OP_SW, OP_BEQ,
    OP_J, OP_JAL, OP_JR, OP_BAD
  } op_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] mdr_q, mdr_d;
  logic        retire_q, retire_d;
  logic        trap_q, trap_d;
  logic [31:0] rf_q [32];

  logic [5:0]  opc, fn;
  logic [4:0]  rs, rt, rd, sh;
  logic [15:0] imm;
  logic [31:0] sext, zext, jtgt;
  logic [31:0] rs_val, rt_val, alu_res;
  op_t         op;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  assign opc  = ir_q[31:26];
  assign rs   = ir_q[25:21];
  assign rt   = ir_q[20:16];
  assign rd   = ir_q[15:11];
  assign sh   = ir_q[10:6];
  assign fn   = ir_q[5:0];
  assign imm  = ir_q[15:0];
  assign sext = {{16{imm[15]}}, imm};
  assign zext = {16'h0000, imm};
  assign jtgt = {pc_q[31:28], ir_q[25:0], 2'b00};

  assign rs_val = (rs == 5'd0) ? 32'h0 : rf_q[rs];
  assign rt_val = (rt == 5'd0) ? 32'h0 : rf_q[rt];

  always_comb begin
    op = OP_BAD;
    unique case (opc)
      6'h00: begin
        unique case (fn)
          6'h21:   op = OP_ADDU;
          6'h23:   op = OP_SUBU;
          6'h24:   op = OP_AND;
          6'h25:   op = OP_OR;
          6'h2a:   op = OP_SLT;
          6'h00:   op = OP_SLL;
`ifdef MIPS_MC_JAL_EN
          6'h08:   op = OP_JR;
`endif
          default: op = OP_BAD;
        endcase
      end
      6'h09:   op = OP_ADDIU;
      6'h0d:   op = OP_ORI;
      6'h0f:   op = OP_LUI;
      6'h23:   op = OP_LW;
      6'h2b:   op = OP_SW;
      6'h04:   op = OP_BEQ;
      6'h02:   op = OP_J;
`ifdef MIPS_MC_JAL_EN
      6'h03:   op = OP_JAL;
`endif
      default: op = OP_BAD;
    endcase
  end

  always_comb begin
    alu_res = 32'h0;
    unique case (op)
      OP_ADDU:                alu_res = a_q + b_q;
      OP_SUBU:                alu_res = a_q - b_q;
      OP_AND:                 alu_res = a_q & b_q;
      OP_OR:                  alu_res = a_q | b_q;
      OP_SLT:                 alu_res = {31'h0, $signed(a_q) < $signed(b_q)};
      OP_SLL:                 alu_res = b_q << sh;
      OP_ADDIU, OP_LW, OP_SW: alu_res = a_q + sext;
      OP_ORI:                 alu_res = a_q | zext;
      OP_LUI:                 alu_res = {imm, 16'h0000};
      OP_JAL:                 alu_res = pc_q;
      default:                alu_res = 32'h0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    alu_d    = alu_q;
    mdr_d    = mdr_q;
    retire_d = 1'b0;
    trap_d   = trap_q;
    rf_we    = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 32'd4;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d = rs_val;
        b_d = rt_val;
        if (op == OP_BAD) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_d = alu_res;
        unique case (op)
          OP_BEQ: begin
            if (a_q == b_q) pc_d = pc_q + {sext[29:0], 2'b00};
            state_d  = S_FETCH;
            retire_d = 1'b1;
          end
          OP_J: begin
            pc_d     = jtgt;
            state_d  = S_FETCH;
            retire_d = 1'b1;
          end
          OP_JR: begin
            pc_d     = a_q;
            state_d  = S_FETCH;
            retire_d = 1'b1;
          end
          OP_JAL: begin
            pc_d    = jtgt;
            state_d = S_WB;
          end
          OP_LW, OP_SW: begin
            if (alu_res[1:0] != 2'b00) begin
              state_d = S_TRAP;
              trap_d  = 1'b1;
            end else begin
              state_d = S_MEM;
            end
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          if (op == OP_SW) begin
            state_d  = S_FETCH;
            retire_d = 1'b1;
          end else begin
            mdr_d   = mem_rdata;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we    = 1'b1;
        state_d  = S_FETCH;
        retire_d = 1'b1;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= 32'h0;
      a_q      <= 32'h0;
      b_q      <= 32'h0;
      alu_q    <= 32'h0;
      mdr_q    <= 32'h0;
      retire_q <= 1'b0;
      trap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      alu_q    <= alu_d;
      mdr_q    <= mdr_d;
      retire_q <= retire_d;
      trap_q   <= trap_d;
    end
  end

  // jal links into $31; R-type writes rd, other I-types write rt
  assign rf_wa = (op == OP_JAL) ? 5'd31 : ((opc == 6'h00) ? rd : rt);
  assign rf_wd = (op == OP_LW) ? mdr_q : alu_q;

  always_ff @(posedge clk) begin
    if (rf_we && !rst && rf_wa != 5'd0) rf_q[rf_wa] <= rf_wd;
  end

  assign mem_req   = !rst && (state_q == S_FETCH || state_q == S_MEM);
  assign mem_we    = !rst && (state_q == S_MEM) && (op == OP_SW);
  assign mem_addr  = (state_q == S_MEM) ? alu_q : pc_q;
  assign mem_wdata = b_q;
  assign pc        = pc_q;
  assign retire    = retire_q;
  assign trap      = trap_q;

endmodule

// File: tb/tb_mips_mc.sv
// tb_mips_mc: directed vectors plus a random program checked against
// an instruction-level model of the core.
module tb_mips_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready = 1'b1;
  logic [31:0] pc;
  logic        retire, trap;

  always #5 clk = ~clk;

  mips_mc #(.RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .pc(pc), .retire(retire), .trap(trap)
  );

  logic [31:0] img [4096];
  logic [31:0] mem [4096];
  logic [31:0] mm [4096];
  logic [31:0] mreg [32];
  logic [31:0] mpc;
  int ready_mode = 0;
  int wait_n = 0;
  int wcnt = 0;
  int wr_cnt = 0;
  int checks = 0;
  int errors = 0;

  assign mem_rdata = mem[mem_addr[13:2]];

  // Memory image is reloaded from img while reset is held
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4096; i++) mem[i] <= img[i];
    end else if (mem_req && mem_we && mem_ready) begin
      mem[mem_addr[13:2]] <= mem_wdata;
    end
  end

  always @(negedge clk) begin
    if (mem_req && mem_we) wr_cnt++;
    case (ready_mode)
      0: mem_ready = 1'b1;
      1: mem_ready = ($urandom_range(0, 2) != 0);
      2: begin
        if (!mem_req) begin
          wcnt = 0;
          mem_ready = 1'b0;
        end else if (wcnt >= wait_n) begin
          wcnt = 0;
          mem_ready = 1'b1;
        end else begin
          wcnt++;
          mem_ready = 1'b0;
        end
      end
      default: mem_ready = 1'b0;
    endcase
  end

  function automatic logic [31:0] enc_r(input logic [4:0] rd, rs, rt, sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op,
                                        input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op,
                                        input logic [25:0] t);
    return {op, t};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < 4096; i++) img[i] = 32'h0;
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] w);
    img[a[13:2]] = w;
  endtask

  task automatic hold_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic run_ret(input int n, input int budget, output int edges,
                         output logic ok);
    int got;
    got = 0;
    edges = 0;
    while (got < n && edges < budget) begin
      @(posedge clk); #1;
      edges++;
      if (retire) got++;
    end
    ok = (got == n);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL retire_timeout: got %0d retires expected %0d", got, n);
    end
  endtask

  task automatic idle(input int n, output int rets);
    rets = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (retire) rets++;
    end
  endtask

  task automatic wreg(input logic [4:0] d, input logic [31:0] v);
    if (d != 5'd0) mreg[d] = v;
  endtask

  task automatic iss_step();
    logic [31:0] w, se, ze, nx, ea;
    logic [4:0]  s, t, d;
    w  = mm[mpc[13:2]];
    s  = w[25:21];
    t  = w[20:16];
    d  = w[15:11];
    se = {{16{w[15]}}, w[15:0]};
    ze = {16'h0000, w[15:0]};
    ea = mreg[s] + se;
    nx = mpc + 32'd4;
    case (w[31:26])
      6'h00: begin
        case (w[5:0])
          6'h21: wreg(d, mreg[s] + mreg[t]);
          6'h23: wreg(d, mreg[s] - mreg[t]);
          6'h24: wreg(d, mreg[s] & mreg[t]);
          6'h25: wreg(d, mreg[s] | mreg[t]);
          6'h2a: wreg(d, ($signed(mreg[s]) < $signed(mreg[t])) ? 32'd1 : 32'd0);
          6'h00: wreg(d, mreg[t] << w[10:6]);
          default: ;
        endcase
      end
      6'h09: wreg(t, mreg[s] + se);
      6'h0d: wreg(t, mreg[s] | ze);
      6'h0f: wreg(t, {w[15:0], 16'h0000});
      6'h23: wreg(t, mm[ea[13:2]]);
      6'h2b: mm[ea[13:2]] = mreg[t];
      6'h04: if (mreg[s] == mreg[t]) nx = nx + (se << 2);
      6'h02: nx = {nx[31:28], w[25:0], 2'b00};
      default: ;
    endcase
    mpc = nx;
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [31:0] ins2;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [11];
  int e, r, w0, term_k;
  logic ok;
  logic [31:0] w, ins;

  initial begin
    vt[0]  = '{enc_r(5'd3, 5'd4, 5'd5, 5'd0, 6'h21), 32'h0,
               32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001};
    vt[1]  = '{enc_r(5'd3, 5'd4, 5'd5, 5'd0, 6'h23), 32'h0,
               32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE};
    vt[2]  = '{enc_r(5'd3, 5'd4, 5'd5, 5'd0, 6'h24), 32'h0,
               32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0};
    vt[3]  = '{enc_r(5'd3, 5'd4, 5'd5, 5'd0, 6'h25), 32'h0,
               32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0};
    vt[4]  = '{enc_r(5'd3, 5'd4, 5'd5, 5'd0, 6'h2a), 32'h0,
               32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
    vt[5]  = '{enc_r(5'd3, 5'd4, 5'd5, 5'd0, 6'h2a), 32'h0,
               32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000};
    vt[6]  = '{enc_r(5'd3, 5'd0, 5'd5, 5'd4, 6'h00), 32'h0,
               32'h0000_0000, 32'h8000_000F, 32'h0000_00F0};
    vt[7]  = '{enc_i(6'h09, 5'd4, 5'd3, 16'hFFFF), 32'h0,
               32'h0000_0010, 32'h0, 32'h0000_000F};
    vt[8]  = '{enc_i(6'h0d, 5'd4, 5'd3, 16'h8000), 32'h0,
               32'h1234_0000, 32'h0, 32'h1234_8000};
    vt[9]  = '{enc_i(6'h0f, 5'd0, 5'd3, 16'hABCD), 32'h0,
               32'h0, 32'h0, 32'hABCD_0000};
    vt[10] = '{enc_r(5'd0, 5'd4, 5'd5, 5'd0, 6'h21),
               enc_r(5'd3, 5'd0, 5'd0, 5'd0, 6'h25),
               32'h0000_0001, 32'h0000_0002, 32'h0000_0000};

    // Reset state and first ori
    clear_img();
    put(32'h3000, enc_i(6'h0d, 5'd0, 5'd1, 16'h00FF));
    ready_mode = 0;
    hold_reset();
    chk("rst_pc", pc, 32'h3000);
    chk("rst_req", 32'(mem_req), 32'h0);
    chk("rst_retire", 32'(retire), 32'h0);
    chk("rst_trap", 32'(trap), 32'h0);
    rst = 1'b0;
    #1;
    chk("first_req", 32'({mem_req, mem_we}), 32'h2);
    chk("first_addr", mem_addr, 32'h3000);
    run_ret(1, 20, e, ok);
    chk("ori_cycles", 32'(e), 32'd4);
    chk("ori_r1", dut.rf_q[1], 32'h0000_00FF);
    chk("ori_pc", pc, 32'h3004);

    // lw with two wait cycles on every access
    clear_img();
    put(32'h3000, enc_i(6'h0d, 5'd0, 5'd1, 16'h0100));
    put(32'h3004, enc_i(6'h23, 5'd1, 5'd2, 16'h0004));
    put(32'h0104, 32'hDEAD_BEEF);
    ready_mode = 2;
    wait_n = 2;
    hold_reset();
    rst = 1'b0;
    run_ret(1, 40, e, ok);
    chk("ori_wait_cycles", 32'(e), 32'd6);
    run_ret(1, 40, e, ok);
    chk("lw_cycles", 32'(e), 32'd9);
    chk("lw_r2", dut.rf_q[2], 32'hDEAD_BEEF);
    chk("lw_pc", pc, 32'h3008);

    // misaligned sw traps without any write request
    clear_img();
    put(32'h3000, enc_i(6'h0d, 5'd0, 5'd1, 16'h0100));
    put(32'h3004, enc_i(6'h2b, 5'd1, 5'd3, 16'h0002));
    ready_mode = 0;
    hold_reset();
    rst = 1'b0;
    run_ret(1, 20, e, ok);
    w0 = wr_cnt;
    idle(3, r);
    chk("sw_mis_trap", 32'(trap), 32'h1);
    idle(10, w);
    chk("sw_mis_retire", 32'(r) + w, 32'h0);
    chk("sw_mis_writes", 32'(wr_cnt - w0), 32'h0);
    chk("sw_mis_req", 32'(mem_req), 32'h0);
    chk("sw_mis_pc", pc, 32'h3008);
    chk("sw_mis_sticky", 32'(trap), 32'h1);

    // taken beq loop
    clear_img();
    put(32'h3010, enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF));
    hold_reset();
    rst = 1'b0;
    run_ret(4, 40, e, ok);
    chk("nop_cycles", 32'(e), 32'd16);
    for (int k = 0; k < 2; k++) begin
      run_ret(1, 10, e, ok);
      chk("beq_t_cycles", 32'(e), 32'd3);
      chk("beq_t_pc", pc, 32'h3010);
    end

    // untaken beq
    clear_img();
    put(32'h3000, enc_i(6'h0d, 5'd0, 5'd1, 16'h0001));
    put(32'h3010, enc_i(6'h04, 5'd1, 5'd0, 16'hFFFF));
    hold_reset();
    rst = 1'b0;
    run_ret(4, 40, e, ok);
    run_ret(1, 10, e, ok);
    chk("beq_nt_cycles", 32'(e), 32'd3);
    chk("beq_nt_pc", pc, 32'h3014);

    // ALU vector table
    for (int v = 0; v < 11; v++) begin
      clear_img();
      put(32'h3000, enc_i(6'h0f, 5'd0, 5'd4, vt[v].a[31:16]));
      put(32'h3004, enc_i(6'h0d, 5'd4, 5'd4, vt[v].a[15:0]));
      put(32'h3008, enc_i(6'h0f, 5'd0, 5'd5, vt[v].b[31:16]));
      put(32'h300C, enc_i(6'h0d, 5'd5, 5'd5, vt[v].b[15:0]));
      put(32'h3010, vt[v].ins);
      put(32'h3014, vt[v].ins2);
      hold_reset();
      rst = 1'b0;
      run_ret(6, 60, e, ok);
      chk($sformatf("alu_vec%0d", v), dut.rf_q[3], vt[v].exp);
    end

    // reset during a stalled fetch
    clear_img();
    put(32'h3000, enc_i(6'h0d, 5'd0, 5'd1, 16'h0077));
    ready_mode = 3;
    hold_reset();
    rst = 1'b0;
    idle(3, r);
    chk("stall_req", 32'({mem_req, mem_we}), 32'h2);
    chk("stall_addr", mem_addr, 32'h3000);
    chk("stall_pc", pc, 32'h3000);
    rst = 1'b1;
    #1;
    chk("abort_req", 32'(mem_req), 32'h0);
    ready_mode = 0;
    hold_reset();
    rst = 1'b0;
    run_ret(1, 20, e, ok);
    chk("restart_cycles", 32'(e), 32'd4);
    chk("restart_r1", dut.rf_q[1], 32'h0000_0077);

    // jal / jr
    clear_img();
    put(32'h3020, enc_j(6'h03, 26'h0000C40));
    put(32'h3024, enc_i(6'h0d, 5'd0, 5'd7, 16'h0055));
    put(32'h3100, enc_r(5'd0, 5'd31, 5'd0, 5'd0, 6'h08));
    hold_reset();
    rst = 1'b0;
    run_ret(8, 64, e, ok);
`ifdef MIPS_MC_JAL_EN
    run_ret(1, 10, e, ok);
    chk("jal_cycles", 32'(e), 32'd4);
    chk("jal_pc", pc, 32'h3100);
    chk("jal_r31", dut.rf_q[31], 32'h3024);
    run_ret(1, 10, e, ok);
    chk("jr_cycles", 32'(e), 32'd3);
    chk("jr_pc", pc, 32'h3024);
    run_ret(1, 10, e, ok);
    chk("jr_after_r7", dut.rf_q[7], 32'h0000_0055);
`else
    idle(4, r);
    chk("jal_off_trap", 32'(trap), 32'h1);
    chk("jal_off_retire", 32'(r), 32'h0);
`endif

    // random program against the instruction-level model
    clear_img();
    for (int i = 0; i < 64; i++) img[64 + i] = $urandom();
    for (int k = 1; k < 32; k++) begin
      img[12'hC00 + 2 * k - 2] = enc_i(6'h0f, 5'd0, 5'(k), 16'($urandom()));
      img[12'hC00 + 2 * k - 1] = enc_i(6'h0d, 5'(k), 5'(k), 16'($urandom()));
    end
    term_k = 162;
    for (int k = 62; k < term_k; k++) begin
      logic [4:0] ra, rb, rc;
      int off;
      logic [31:0] tgt;
      ra = 5'($urandom());
      rb = 5'($urandom());
      rc = 5'($urandom());
      off = $urandom_range(0, 3);
      if (k + 1 + off > term_k) off = term_k - k - 1;
      tgt = 32'h3000 + 32'(4 * (k + 1 + off));
      case ($urandom_range(0, 12))
        0:  ins = enc_r(rc, ra, rb, 5'd0, 6'h21);
        1:  ins = enc_r(rc, ra, rb, 5'd0, 6'h23);
        2:  ins = enc_r(rc, ra, rb, 5'd0, 6'h24);
        3:  ins = enc_r(rc, ra, rb, 5'd0, 6'h25);
        4:  ins = enc_r(rc, ra, rb, 5'd0, 6'h2a);
        5:  ins = enc_r(rc, 5'd0, rb, 5'($urandom()), 6'h00);
        6:  ins = enc_i(6'h09, ra, rb, 16'($urandom()));
        7:  ins = enc_i(6'h0d, ra, rb, 16'($urandom()));
        8:  ins = enc_i(6'h0f, 5'd0, rb, 16'($urandom()));
        9:  ins = enc_i(6'h23, 5'd0, rb, 16'(32'h100 + 4 * $urandom_range(0, 63)));
        10: ins = enc_i(6'h2b, 5'd0, rb, 16'(32'h100 + 4 * $urandom_range(0, 63)));
        11: ins = enc_i(6'h04, ra, ($urandom_range(0, 1) == 1) ? ra : rb, 16'(off));
        default: ins = enc_j(6'h02, tgt[27:2]);
      endcase
      img[12'hC00 + k] = ins;
    end
    img[12'hC00 + term_k] = enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF);
    for (int i = 0; i < 4096; i++) mm[i] = img[i];
    for (int i = 0; i < 32; i++) mreg[i] = 32'h0;
    mpc = 32'h3000;
    ready_mode = 1;
    hold_reset();
    rst = 1'b0;
    while (mpc != 32'h3000 + 32'(4 * term_k)) begin
      run_ret(1, 80, e, ok);
      if (!ok) break;
      iss_step();
      chk("rnd_pc", pc, mpc);
    end
    for (int i = 1; i < 32; i++) chk($sformatf("rnd_reg%0d", i), dut.rf_q[i], mreg[i]);
    for (int i = 0; i < 64; i++) chk($sformatf("rnd_mem%0d", i), mem[64 + i], mm[64 + i]);
    chk("rnd_trap", 32'(trap), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
